// File: rtl/note_bank_pkg.sv
// Shared definitions for the note_bank voice: widths, FSM state codes, helpers.
package note_bank_pkg;

    localparam int NB_LEVEL_W  = 18;
    localparam int NB_TIME_W   = 32;
    localparam int NB_PERIOD_W = 23;
    localparam int NB_OUT_W    = 24;
    localparam int OUT_SHIFT   = 5;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_ATTACK  = 3'd1;
    localparam state_t S_DECAY   = 3'd2;
    localparam state_t S_SUSTAIN = 3'd3;
    localparam state_t S_RELEASE = 3'd4;

    // Unsigned distance between two envelope levels.
    function automatic logic [NB_LEVEL_W-1:0] level_dist(input logic [NB_LEVEL_W-1:0] a,
                                                         input logic [NB_LEVEL_W-1:0] b);
        logic [NB_LEVEL_W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

endpackage

// File: rtl/note_bank_if.sv
// Control/audio bundle between note-control logic (master) and the voice (slave).
interface note_bank_if #(
    parameter int LEVEL_W  = note_bank_pkg::NB_LEVEL_W,
    parameter int TIME_W   = note_bank_pkg::NB_TIME_W,
    parameter int PERIOD_W = note_bank_pkg::NB_PERIOD_W,
    parameter int OUT_W    = note_bank_pkg::NB_OUT_W
);
    logic                note_on;
    logic                note_off;
    logic [PERIOD_W-1:0] period;
    logic [LEVEL_W-1:0]  ab;
    logic [LEVEL_W-1:0]  ac;
    logic [TIME_W-1:0]   x;
    logic [TIME_W-1:0]   y;
    logic [TIME_W-1:0]   z;
    logic [OUT_W-1:0]    audio_out;
    logic                done;

    modport master (
        output note_on, note_off, period, ab, ac, x, y, z,
        input  audio_out, done
    );

    modport slave (
        input  note_on, note_off, period, ab, ac, x, y, z,
        output audio_out, done
    );
endinterface

// File: rtl/note_env_ramp.sv
// Linear envelope ramp: Bresenham-style error accumulator moving level from
// start to target in exactly `duration` cycles, snapping on the final cycle.
module note_env_ramp import note_bank_pkg::*; #(
    parameter int LEVEL_W = NB_LEVEL_W,
    parameter int TIME_W  = NB_TIME_W
) (
    input  logic               clk_slow,
    input  logic               rst_b,
    input  logic               load_i,
    input  logic               enable_i,
    input  logic [LEVEL_W-1:0] start_i,
    input  logic [LEVEL_W-1:0] target_i,
    input  logic [TIME_W-1:0]  duration_i,
    output logic [LEVEL_W-1:0] level_o,
    output logic               last_o
);

    logic [LEVEL_W-1:0] level_q,  level_d;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic [LEVEL_W-1:0] delta_q,  delta_d;
    logic               up_q,     up_d;
    logic [TIME_W-1:0]  dur_q,    dur_d;
    logic [TIME_W-1:0]  cnt_q,    cnt_d;
    logic [TIME_W:0]    err_q,    err_d;

    logic [TIME_W:0]    err_sum_s;
    logic [TIME_W:0]    err_rem_s;
    logic [TIME_W:0]    dur_ext_s;
    logic               step_s;

    assign dur_ext_s = {1'b0, dur_q};
    assign err_sum_s = err_q + {{(TIME_W + 1 - LEVEL_W){1'b0}}, delta_q};
    assign err_rem_s = err_sum_s - dur_ext_s;
    assign step_s    = (err_sum_s >= dur_ext_s);
    assign last_o    = (dur_q == {TIME_W{1'b0}}) || (cnt_q == (dur_q - TIME_W'(1)));
    assign level_o   = level_q;

    // Next-state: load a new phase, advance the ramp, or hold.
    always_comb begin
        level_d  = level_q;
        target_d = target_q;
        delta_d  = delta_q;
        up_d     = up_q;
        dur_d    = dur_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (load_i) begin
            target_d = target_i;
            delta_d  = level_dist(target_i, start_i);
            up_d     = (target_i >= start_i);
            dur_d    = duration_i;
            cnt_d    = {TIME_W{1'b0}};
            err_d    = {(TIME_W + 1){1'b0}};
            if (duration_i == {TIME_W{1'b0}}) begin
                level_d = target_i;
            end else begin
                level_d = start_i;
            end
        end else if (enable_i) begin
            if (last_o) begin
                level_d = target_q;
            end else begin
                cnt_d = cnt_q + TIME_W'(1);
                if (step_s) begin
                    // Cap keeps err bounded when the slope exceeds 1 LSB/cycle.
                    if (err_rem_s >= dur_ext_s) begin
                        err_d = dur_ext_s;
                    end else begin
                        err_d = err_rem_s;
                    end
                    if (up_q) begin
                        level_d = level_q + LEVEL_W'(1);
                    end else begin
                        level_d = level_q - LEVEL_W'(1);
                    end
                end else begin
                    err_d = err_sum_s;
                end
            end
        end else begin
            level_d = level_q;
        end
    end

    // Ramp state registers.
    always_ff @(posedge clk_slow or negedge rst_b) begin
        if (!rst_b) begin
            level_q  <= {LEVEL_W{1'b0}};
            target_q <= {LEVEL_W{1'b0}};
            delta_q  <= {LEVEL_W{1'b0}};
            up_q     <= 1'b0;
            dur_q    <= {TIME_W{1'b0}};
            cnt_q    <= {TIME_W{1'b0}};
            err_q    <= {(TIME_W + 1){1'b0}};
        end else begin
            level_q  <= level_d;
            target_q <= target_d;
            delta_q  <= delta_d;
            up_q     <= up_d;
            dur_q    <= dur_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: rtl/note_bank.sv
// Single synth voice: ADSR FSM driving a ramp, square oscillator, signed output.
module note_bank import note_bank_pkg::*; #(
    parameter int LEVEL_W  = NB_LEVEL_W,
    parameter int TIME_W   = NB_TIME_W,
    parameter int PERIOD_W = NB_PERIOD_W,
    parameter int OUT_W    = NB_OUT_W
) (
    input  logic       clk_slow,
    input  logic       rst_b,
    note_bank_if.slave bus
);

    state_t              state_q,  state_d;
    logic [PERIOD_W-1:0] phase_q,  phase_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [OUT_W-1:0]    audio_q,  audio_d;
    logic                done_q,   done_d;

    logic                ramp_load_s;
    logic                ramp_en_s;
    logic [LEVEL_W-1:0]  ramp_start_s;
    logic [LEVEL_W-1:0]  ramp_target_s;
    logic [TIME_W-1:0]   ramp_dur_s;
    logic [LEVEL_W-1:0]  level_s;
    logic                last_s;
    logic [OUT_W-1:0]    mag_s;

    note_env_ramp #(
        .LEVEL_W (LEVEL_W),
        .TIME_W  (TIME_W)
    ) u_ramp (
        .clk_slow   (clk_slow),
        .rst_b      (rst_b),
        .load_i     (ramp_load_s),
        .enable_i   (ramp_en_s),
        .start_i    (ramp_start_s),
        .target_i   (ramp_target_s),
        .duration_i (ramp_dur_s),
        .level_o    (level_s),
        .last_o     (last_s)
    );

    assign ramp_en_s = (state_q == S_ATTACK) || (state_q == S_DECAY) || (state_q == S_RELEASE);
    assign mag_s     = {{(OUT_W - LEVEL_W - OUT_SHIFT){1'b0}}, level_s, {OUT_SHIFT{1'b0}}};

    assign bus.audio_out = audio_q;
    assign bus.done      = done_q;

    // Envelope FSM: note_on beats note_off, which beats natural phase ends.
    always_comb begin
        state_d       = state_q;
        done_d        = 1'b0;
        ramp_load_s   = 1'b0;
        ramp_start_s  = level_s;
        ramp_target_s = bus.ab;
        ramp_dur_s    = bus.x;
        case (state_q)
            S_IDLE: begin
                if (bus.note_on) begin
                    state_d     = S_ATTACK;
                    ramp_load_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ATTACK, S_DECAY, S_SUSTAIN: begin
                if (bus.note_on) begin
                    state_d     = S_ATTACK;
                    ramp_load_s = 1'b1;
                end else if (bus.note_off) begin
                    state_d       = S_RELEASE;
                    ramp_load_s   = 1'b1;
                    ramp_target_s = {LEVEL_W{1'b0}};
                    ramp_dur_s    = bus.z;
                end else if ((state_q == S_ATTACK) && last_s) begin
                    state_d       = S_DECAY;
                    ramp_load_s   = 1'b1;
                    ramp_start_s  = bus.ab;
                    ramp_target_s = bus.ac;
                    ramp_dur_s    = bus.y;
                end else if ((state_q == S_DECAY) && last_s) begin
                    state_d = S_SUSTAIN;
                end else begin
                    state_d = state_q;
                end
            end
            S_RELEASE: begin
                if (bus.note_on) begin
                    state_d     = S_ATTACK;
                    ramp_load_s = 1'b1;
                end else if (last_s) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Oscillator: phase wraps at period-1; a new period is picked up only on wrap.
    always_comb begin
        phase_d  = phase_q;
        period_d = period_q;
        if (state_q == S_IDLE) begin
            phase_d  = {PERIOD_W{1'b0}};
            period_d = bus.period;
        end else if (period_q <= PERIOD_W'(1)) begin
            phase_d  = {PERIOD_W{1'b0}};
            period_d = bus.period;
        end else if (phase_q == (period_q - PERIOD_W'(1))) begin
            phase_d  = {PERIOD_W{1'b0}};
            period_d = bus.period;
        end else begin
            phase_d = phase_q + PERIOD_W'(1);
        end
    end

    // Output stage: +m in the first half-period, -m in the second, silent when idle.
    always_comb begin
        audio_d = {OUT_W{1'b0}};
        if (state_q == S_IDLE) begin
            audio_d = {OUT_W{1'b0}};
        end else if (phase_q < (period_q >> 1)) begin
            audio_d = mag_s;
        end else begin
            audio_d = {OUT_W{1'b0}} - mag_s;
        end
    end

    // Voice state, oscillator and output registers.
    always_ff @(posedge clk_slow or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= S_IDLE;
            phase_q  <= {PERIOD_W{1'b0}};
            period_q <= {PERIOD_W{1'b0}};
            audio_q  <= {OUT_W{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            audio_q  <= audio_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_note_bank.sv
// Self-checking bench for note_bank: cycle model feeding a scoreboard queue.
module tb_note_bank;
    import note_bank_pkg::*;

    logic clk_slow = 1'b0;
    logic rst_b;

    note_bank_if bus ();

    note_bank dut (
        .clk_slow (clk_slow),
        .rst_b    (rst_b),
        .bus      (bus.slave)
    );

    always #5 clk_slow = ~clk_slow;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_seen    = 0;

    typedef struct {
        longint audio;
        longint done;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state.
    logic [2:0] ms;
    longint ml, ml0, ml1, mn, mk, mph, mper;

    task automatic check_val(input string tag, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic longint aud_signed();
        logic signed [23:0] v;
        v = bus.audio_out;
        return longint'(v);
    endfunction

    function automatic longint aud_abs();
        longint v;
        v = aud_signed();
        return (v < 0) ? -v : v;
    endfunction

    // Closed-form ramp level after k of n cycles (k < n).
    function automatic longint ramp_at(input longint l0, input longint l1,
                                       input longint n, input longint k);
        longint d, s;
        d = (l1 >= l0) ? (l1 - l0) : (l0 - l1);
        s = (d <= n) ? ((k * d) / n) : k;
        return (l1 >= l0) ? (l0 + s) : (l0 - s);
    endfunction

    task automatic model_reset();
        ms = S_IDLE; ml = 0; ml0 = 0; ml1 = 0; mn = 0; mk = 0; mph = 0; mper = 0;
    endtask

    task automatic model_start(input logic [2:0] st, input longint l0,
                               input longint l1, input longint n);
        ms = st; ml0 = l0; ml1 = l1; mn = n; mk = 0;
        ml = (n == 0) ? l1 : l0;
    endtask

    task automatic model_step(output longint ea, output longint ed);
        longint nph, nper;
        bit ramping, last_v;
        if (ms == S_IDLE) ea = 0;
        else if (mph < (mper >> 1)) ea = ml * 32;
        else ea = -(ml * 32);
        ed = 0;
        ramping = (ms == S_ATTACK) || (ms == S_DECAY) || (ms == S_RELEASE);
        last_v  = ramping && ((mn == 0) || (mk == mn - 1));
        if ((ms == S_IDLE) || (mper <= 1) || (mph == mper - 1)) begin
            nph = 0; nper = longint'(bus.period);
        end else begin
            nph = mph + 1; nper = mper;
        end
        if (ms == S_IDLE) begin
            if (bus.note_on) model_start(S_ATTACK, ml, longint'(bus.ab), longint'(bus.x));
        end else if (bus.note_on) begin
            model_start(S_ATTACK, ml, longint'(bus.ab), longint'(bus.x));
        end else if (ms == S_RELEASE) begin
            if (last_v) begin
                ms = S_IDLE; ml = ml1; ed = 1;
            end else begin
                mk++; ml = ramp_at(ml0, ml1, mn, mk);
            end
        end else if (bus.note_off) begin
            model_start(S_RELEASE, ml, 0, longint'(bus.z));
        end else if ((ms == S_ATTACK) && last_v) begin
            model_start(S_DECAY, longint'(bus.ab), longint'(bus.ac), longint'(bus.y));
        end else if ((ms == S_DECAY) && last_v) begin
            ms = S_SUSTAIN; ml = ml1;
        end else if (ramping) begin
            mk++; ml = ramp_at(ml0, ml1, mn, mk);
        end
        mph = nph; mper = nper;
    endtask

    // One clock: model predicts at the edge, DUT output checked 1 time unit later.
    task automatic tick();
        exp_t e;
        longint ea, ed;
        @(posedge clk_slow);
        model_step(ea, ed);
        e.audio = ea; e.done = ed;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check_val("audio", aud_signed(), e.audio);
        check_val("done", longint'(bus.done), e.done);
        if (bus.done) done_seen++;
        bus.note_on  = 1'b0;
        bus.note_off = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input int budget, output int n_out);
        n_out = -1;
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (bus.done) begin
                n_out = n;
                break;
            end
        end
    endtask

    initial begin
        int n;
        rst_b = 1'b0;
        bus.note_on = 1'b0; bus.note_off = 1'b0;
        bus.period = 23'd1000; bus.ab = 18'd128; bus.ac = 18'd64;
        bus.x = 32'd10000; bus.y = 32'd10000; bus.z = 32'd10000;
        model_reset();
        #22;
        check_val("reset_audio", aud_signed(), 0);
        check_val("reset_done", longint'(bus.done), 0);
        rst_b = 1'b1;
        run(5);

        // Attack / decay / sustain / release with long phases.
        bus.note_on = 1'b1;
        tick();
        for (int i = 1; i <= 30000; i++) begin
            tick();
            if (i == 501)   check_val("att_neg_half", aud_signed(), -192);
            if (i == 5001)  check_val("att_mid", aud_signed(), 2048);
            if (i == 10001) check_val("att_peak", aud_signed(), 4096);
            if (i == 20001) check_val("sustain", aud_signed(), 2048);
        end
        bus.note_off = 1'b1;
        tick();
        wait_done(10100, n);
        check_val("rel_len", n, 10000);
        run(10);
        check_val("idle_after_rel", aud_signed(), 0);

        // Early release from the middle of attack.
        bus.note_on = 1'b1;
        tick();
        run(5000);
        bus.note_off = 1'b1;
        tick();
        wait_done(10100, n);
        check_val("early_rel_len", n, 10000);

        // Retrigger during release at level 32.
        bus.period = 23'd20;
        bus.x = 32'd100; bus.y = 32'd100; bus.z = 32'd100;
        bus.note_on = 1'b1;
        tick();
        run(250);
        bus.note_off = 1'b1;
        tick();
        run(50);
        done_seen = 0;
        bus.note_on = 1'b1;
        tick();
        tick();
        check_val("retrig_level", aud_abs(), 1024);
        run(249);
        check_val("retrig_no_done", done_seen, 0);

        // Simultaneous note_on + note_off while sustaining.
        bus.note_on = 1'b1; bus.note_off = 1'b1;
        tick();
        for (int i = 1; i <= 101; i++) begin
            tick();
            if (i == 101) check_val("both_attack_peak", aud_abs(), 4096);
        end
        check_val("both_no_done", done_seen, 0);
        bus.note_off = 1'b1;
        tick();
        wait_done(200, n);
        check_val("rel_len_short", n, 100);

        // Zero-length attack.
        bus.x = 32'd0;
        bus.note_on = 1'b1;
        tick();
        tick();
        check_val("x0_level", aud_signed(), 4096);
        run(10);
        bus.note_off = 1'b1;
        tick();
        wait_done(200, n);
        check_val("x0_rel_len", n, 100);

        // note_off while idle is ignored.
        done_seen = 0;
        bus.note_off = 1'b1;
        tick();
        run(20);
        check_val("idle_off_no_done", done_seen, 0);

        // Asynchronous reset in the middle of an attack.
        bus.x = 32'd1000;
        bus.note_on = 1'b1;
        tick();
        run(50);
        #2;
        rst_b = 1'b0;
        #1;
        check_val("rst_async_audio", aud_signed(), 0);
        check_val("rst_async_done", longint'(bus.done), 0);
        model_reset();
        sb_q.delete();
        #3;
        rst_b = 1'b1;
        run(10);
        bus.x = 32'd0;
        bus.note_on = 1'b1;
        tick();
        tick();
        check_val("post_rst_start", aud_signed(), 4096);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/note_bank.md
Name: note_bank

Overview:
- Single-voice synthesiser note: a square-wave oscillator with a programmable period, amplitude-scaled by a linear attack/decay/sustain/release envelope.
- Triggered by note_on and note_off pulses.
- Produces a signed 24-bit audio sample every clock.
- Pulses done when the release completes.
- Sits between the note-control logic and the audio mixer.

Parameters:
- LEVEL_W, 18, envelope level width (ab, ac).
- TIME_W, 32, phase duration width (x, y, z).
- PERIOD_W, 23, oscillator period width.
- OUT_W, 24, audio sample width.

Ports:
- clk_slow  in  1  sample clock; the only clock.
- rst_b  in  1  asynchronous active-low reset.
- note_on  in  1  one-cycle start/retrigger pulse.
- note_off  in  1  one-cycle release pulse.
- period  in  23  oscillator period in clk_slow cycles.
- ab  in  18  unsigned peak level (attack target).
- ac  in  18  unsigned sustain level (decay target).
- x  in  32  attack duration in cycles.
- y  in  32  decay duration in cycles.
- z  in  32  release duration in cycles.
- audio_out  out  24  signed sample, registered.
- done  out  1  one-cycle pulse at end of release.

Behaviour:
- Interface: one clock (clk_slow); reset is asynchronous and active-low (rst_b).
- Reset: state=IDLE, level=0, phase=0, ramp counters=0, audio_out=0, done=0.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Ramp rule, applied to each ramp phase (start L0, target L1, duration N):
  - On entry: cnt=0, err=0.
  - Each cycle: err+=|L1-L0|. If err>=N, level steps 1 LSB toward L1 and err-=N.
  - On the cycle where cnt==N-1: level<=L1 exactly and the FSM advances.
  - The phase therefore lasts exactly N cycles.
  - If |L1-L0|>N, the per-cycle step stays capped at 1 LSB and the final cycle snaps level to L1.
  - N==0: level<=L1 on the entry cycle and the FSM advances on the next cycle.
- Transitions:
  - IDLE --note_on--> ATTACK (L0=level, L1=ab, N=x); phase<=0.
  - ATTACK end -> DECAY (L0=ab, L1=ac, N=y).
  - DECAY end -> SUSTAIN; level holds ac.
  - ATTACK, DECAY or SUSTAIN --note_off--> RELEASE (L0=current level, L1=0, N=z).
  - RELEASE end -> IDLE, done=1 for exactly that one cycle.
  - note_on in any non-IDLE state: retrigger ATTACK from the current level; phase not reset.
  - note_on and note_off in the same cycle: note_on wins.
  - note_off in IDLE: ignored.
- Oscillator:
  - Phase counter counts 0..period-1 and wraps; free-running while state != IDLE.
  - period<=1: phase held at 0.
- Output (registered, 1-cycle latency from level/phase):
  - Magnitude m = level<<5 (max 0x7FFFE0, fits signed 24).
  - audio_out = +m if phase < period>>1, else -m (two's complement).
  - In IDLE, audio_out=0.
- Inputs ab, ac, x, y, z, period are sampled continuously. Changes take effect at the next phase entry; period changes take effect at the next wrap.
- No overflow: err is held in 33 bits.

Decomposition:
- Shared package: the state enum {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE}, the width constants, and OUT_SHIFT=5.
- One sub-module: note_env_ramp, implementing the ramp rule (inputs: start, target, duration, load, enable; outputs: level, last).
- The FSM, oscillator and output stage stay in note_bank.

Test Plan:
- Reset mid-ATTACK: assert rst_b=0 -> audio_out=0, done=0 immediately (asynchronous); after release of reset, state is IDLE.
- Attack and decay (ab=128, ac=64, x=y=z=10000, period=1000, note_on pulse):
  - Sign flips every 500 cycles.
  - |audio_out|=2048 at cycle 5000 (level 64).
  - |audio_out|=4096 at cycle 10000.
  - Decreasing to 2048 at cycle 20000, then constant (sustain).
- Release: note_off at cycle 30000 -> level linear to 0 over 10000 cycles; done high exactly one cycle at cycle 40000; audio_out=0 afterwards.
- Early release: note_off at attack cycle 5000 (level 64) -> RELEASE from 64; done after 10000 cycles; decay never entered.
- Retrigger: note_on during RELEASE at level 32 -> ATTACK from 32 to 128 over x cycles; no done pulse.
- Edge cases:
  - x=0 -> level=128 one cycle after note_on.
  - Simultaneous note_on+note_off in SUSTAIN -> ATTACK.
  - note_off in IDLE -> no done.
